// File: rtl/clk_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_enable_gen
// Purpose  : Derives a free-running tick from clk25 and gates it into a CPU
//            clock enable that supports free-run and single-step operation
//            driven by a debounced push-button.
// Ports    : clk25       - system clock (25 MHz)
//            rst_n       - synchronous active-low reset
//            single_step - async level, 1 = single-step mode, 0 = free run
//            step_btn    - async raw push-button, active-high, bouncing
//            tick        - one-cycle pulse every DIVIDE cycles (always runs)
//            cpu_en      - one-cycle CPU clock enable, gated by run/step state
//            halted      - high while the CPU is stopped awaiting a step
// Revision : 1.0 - initial release
// ============================================================================
module clk_enable_gen #(
  parameter int DIVIDE   = 25,
  parameter int DEBOUNCE = 250000
) (
  input  logic clk25,
  input  logic rst_n,
  input  logic single_step,
  input  logic step_btn,
  output logic tick,
  output logic cpu_en,
  output logic halted
);

  localparam int DIV_W = (DIVIDE   > 1) ? $clog2(DIVIDE)   : 1;
  localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(DIVIDE - 1);
  localparam logic [DEB_W-1:0] c_deb_last = DEB_W'(DEBOUNCE - 1);

  // --------------------------------------------------------------------------
  // Two-flop synchronisers for both asynchronous inputs
  // --------------------------------------------------------------------------
  logic r_ss_meta;
  logic r_ss_sync;
  logic r_btn_meta;
  logic r_btn_sync;

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      r_ss_meta  <= 1'b0;
      r_ss_sync  <= 1'b0;
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
    end else begin
      r_ss_meta  <= single_step;
      r_ss_sync  <= r_ss_meta;
      r_btn_meta <= step_btn;
      r_btn_sync <= r_btn_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Free-running divider; independent of mode and step activity
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] r_div_cnt;

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == c_div_last) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  assign tick = (r_div_cnt == c_div_last);

  // --------------------------------------------------------------------------
  // Debouncer: the level flips only after DEBOUNCE consecutive cycles in
  // which the synchronised button disagrees with it; any agreement restarts
  // the count.
  // --------------------------------------------------------------------------
  logic [DEB_W-1:0] r_db_cnt;
  logic             r_db_level;
  logic             w_db_diff;
  logic             w_db_flip;
  logic             w_press;

  assign w_db_diff = (r_btn_sync != r_db_level);
  assign w_db_flip = w_db_diff && (r_db_cnt == c_deb_last);
  // Only the rising debounced edge is a press; release is silent.
  assign w_press   = w_db_flip && !r_db_level;

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
    end else if (!w_db_diff) begin
      r_db_cnt   <= '0;
    end else if (w_db_flip) begin
      r_db_cnt   <= '0;
      r_db_level <= ~r_db_level;
    end else begin
      r_db_cnt   <= r_db_cnt + DEB_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Run / step state machine
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_ARMED  = 2'd2
  } state_t;

  state_t r_state;
  logic   r_halted;

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_ss_sync) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          // Leaving step mode wins over a press arriving on the same edge.
          if (!r_ss_sync) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end else if (w_press) begin
            r_state  <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          // Presses are not looked at here, so they can never be queued.
          if (!r_ss_sync) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end else if (tick) begin
            r_state  <= ST_HALTED;
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // cpu_en has to land in the very cycle of tick, so it is a gate on the
  // combinational tick rather than a register; the gating term is registered.
  assign cpu_en = tick && (r_state != ST_HALTED);
  assign halted = r_halted;

endmodule
`default_nettype wire

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 Parameter DIVIDE, default 25, clk25 cycles per enable period; legal range 2..1024; default gives 1 MHz.
REQ-002 Parameter DEBOUNCE, default 250000, consecutive stable clk25 cycles before the step button is accepted; default is 10 ms.
REQ-003 clk25  input  1  system clock, 25 MHz.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 single_step  input  1  asynchronous level; 1 = single-step mode, 0 = free run.
REQ-006 step_btn  input  1  asynchronous raw push-button, active-high, bouncing.
REQ-007 tick  output  1  free-running one-cycle pulse every DIVIDE cycles; drives the enable of the power-on reset generator.
REQ-008 cpu_en  output  1  one-cycle CPU clock enable, gated by run/step state.
REQ-009 halted  output  1  high while the CPU is stopped awaiting a step.

Function
REQ-010 single_step and step_btn shall each pass through a two-flop synchroniser on clk25 before any use.
REQ-011 Divider: div_cnt shall count 0..DIVIDE-1 and wrap to 0; it shall run in every state and is unaffected by mode or step.
REQ-012 tick shall be a combinational decode of div_cnt==DIVIDE-1: exactly one high cycle per DIVIDE cycles, no gaps, no doubles.
REQ-013 Debounce: a counter shall increment while the synchronised button differs from the debounced level, and clear to 0 when they match.
REQ-014 The debounced level shall toggle when the counter reaches DEBOUNCE-1; the counter shall then clear to 0.
REQ-015 A press event is a one-cycle pulse on a debounced 0->1 transition; release (1->0) shall produce no event.
REQ-016 FSM states: RUN, HALTED, ARMED.
REQ-017 RUN: cpu_en=tick; synchronised single_step=1 -> HALTED on the next edge.
REQ-018 HALTED: cpu_en=0, halted=1; single_step=0 -> RUN, which takes priority over a simultaneous press; otherwise a press event -> ARMED.
REQ-019 ARMED: halted=1; on the next tick, cpu_en=1 for that one cycle, then -> HALTED.
REQ-020 ARMED: press events shall be ignored, i.e. never queued.
REQ-021 ARMED: single_step=0 -> RUN on the next edge; a tick in that same cycle still produces cpu_en.
REQ-022 cpu_en shall never be high outside a tick cycle.
REQ-023 cpu_en shall be high at most once per DIVIDE cycles.
REQ-024 Counter widths: $clog2 of the respective parameter, minimum 1 bit; no overflow past the terminal value.

Reset
REQ-025 While rst_n=0 at a clk25 edge: div_cnt=0, debounce counter=0, debounced level=0, synchroniser flops=0, state=RUN.
REQ-026 Resulting values in reset: tick=0, cpu_en=0, halted=0.
REQ-027 First tick shall occur in cycle DIVIDE-1, counting the first cycle after rst_n rises as cycle 0.
REQ-028 Reset asserted mid-debounce or in ARMED shall discard the pending press; no cpu_en shall follow the reset.

Verification
REQ-029 Free run, DIVIDE=25, single_step=0: reset release, then 1000 cycles -> exactly 40 tick pulses, cpu_en identical to tick, first tick at cycle 24, halted=0.
REQ-030 Enter step mode: raise single_step -> halted=1 within 3 cycles (synchroniser + FSM); zero cpu_en over the following 500 cycles while tick continues.
REQ-031 Debounce, DEBOUNCE=16 for sim: step_btn toggled every 5 cycles for 100 cycles, then held 1 -> exactly one cpu_en, coinciding with the first tick after 16 stable cycles plus sync latency; none during bouncing.
REQ-032 Press during ARMED: second clean press before the pending tick -> only one cpu_en; state returns to HALTED; halted remains 1.
REQ-033 Return to run: in HALTED, drop single_step simultaneously with a press -> RUN; cpu_en resumes on every tick.
REQ-034 Reset mid-operation: assert rst_n=0 for 1 cycle while ARMED -> cpu_en=0 and halted=0 at the next edge; first tick exactly DIVIDE-1 cycles after release; no stray step.
